// File: rtl/asram16_device_model.sv
// asram16_device_model
//   Pin-level responder that behaves like a 16-bit asynchronous SRAM. It sits
//   on the controller's SRAM pins and samples them on the controller's clock.
//   Data is kept in a 2^ADDR_W x 16 array. Read data comes back after a
//   programmable latency. The block also watches the controller's pin timing
//   and raises sticky violation flags.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous clear of counters and sticky flags
//   sram_*_i            controller-driven SRAM pins (address, write data,
//                       oe_n, cs_n, be_n, we_n)
//   sram_data_in_o      read data (INVALID_DATA while not valid)
//   rd_valid_o          sram_data_in_o holds array data
//   write_count_o       committed writes (wraps)
//   read_count_o        completed read accesses (wraps)
//   viol_we_width_o     sticky: we_n low pulse shorter than MIN_WE_CYCLES
//   viol_addr_o         sticky: address/data moved while we_n was low
//   viol_conflict_o     sticky: we_n and oe_n low together under cs_n
module asram16_device_model #(
  parameter int          ADDR_W        = 10,
  parameter logic [3:0]  READ_LATENCY  = 4'd3,
  parameter logic [3:0]  MIN_WE_CYCLES = 4'd2,
  parameter logic [15:0] INVALID_DATA  = 16'hDEAD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] sram_address_i,
  input  logic [15:0] sram_data_out_i,
  input  logic        sram_oe_n_i,
  input  logic        sram_cs_n_i,
  input  logic [1:0]  sram_be_n_i,
  input  logic        sram_we_n_i,
  output logic [15:0] sram_data_in_o,
  output logic        rd_valid_o,
  output logic [15:0] write_count_o,
  output logic [15:0] read_count_o,
  output logic        viol_we_width_o,
  output logic        viol_addr_o,
  output logic        viol_conflict_o
);

  typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;

  // Input sampling stage; every decision below uses these values
  logic              r_s_cs_n, r_s_we_n, r_s_oe_n;
  logic [1:0]        r_s_be_n;
  logic [ADDR_W-1:0] r_s_addr, r_prev_addr;
  logic [15:0]       r_s_data;

  // Write tracking
  wstate_t           r_wstate;
  logic [ADDR_W-1:0] r_w_addr;
  logic [15:0]       r_w_data;
  logic [1:0]        r_w_be_n;
  logic [3:0]        r_we_cnt;

  // Read tracking
  logic [3:0]        r_rd_cnt;
  logic [3:0]        w_rd_cnt_nxt;

  logic [15:0]       r_mem [2**ADDR_W];

  // Upper address bits alias onto the array and are deliberately dropped
  logic w_unused_addr;
  assign w_unused_addr = |sram_address_i[31:ADDR_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s_cs_n    <= 1'b1;
      r_s_we_n    <= 1'b1;
      r_s_oe_n    <= 1'b1;
      r_s_be_n    <= 2'b11;
      r_s_addr    <= '0;
      r_s_data    <= '0;
      r_prev_addr <= '0;
    end else begin
      r_s_cs_n    <= sram_cs_n_i;
      r_s_we_n    <= sram_we_n_i;
      r_s_oe_n    <= sram_oe_n_i;
      r_s_be_n    <= sram_be_n_i;
      r_s_addr    <= sram_address_i[ADDR_W-1:0];
      r_s_data    <= sram_data_out_i;
      r_prev_addr <= r_s_addr;
    end
  end

  logic w_wr_low, w_commit, w_width_viol, w_addr_viol, w_conflict;
  logic w_rd_cond, w_rd_hit, w_rd_done;

  assign w_wr_low     = !r_s_cs_n && !r_s_we_n;
  // Rising we_n (or cs_n) seen in the sampled pins ends the write
  assign w_commit     = (r_wstate == W_ACTIVE) && !w_wr_low;
  assign w_width_viol = w_commit && (r_we_cnt < MIN_WE_CYCLES);
  assign w_addr_viol  = (r_wstate == W_ACTIVE) && w_wr_low &&
                        ((r_s_addr != r_w_addr) || (r_s_data != r_w_data));
  assign w_conflict   = w_wr_low && !r_s_oe_n;
  // A conflicting cycle has we_n low, so it never counts as a read
  assign w_rd_cond    = !r_s_cs_n && !r_s_oe_n && r_s_we_n;

  always_comb begin
    w_rd_cnt_nxt = 4'd0;
    if (w_rd_cond && (r_s_addr == r_prev_addr))
      w_rd_cnt_nxt = (r_rd_cnt == READ_LATENCY) ? READ_LATENCY : r_rd_cnt + 4'd1;
  end

  assign w_rd_hit  = (w_rd_cnt_nxt == READ_LATENCY);
  // Count a read once per stable address, on entry into the valid window
  assign w_rd_done = w_rd_hit && (r_rd_cnt != READ_LATENCY);

  // Write FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_w_addr <= '0;
      r_w_data <= '0;
      r_w_be_n <= 2'b11;
      r_we_cnt <= 4'd0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_low) begin
            r_wstate <= W_ACTIVE;
            r_w_addr <= r_s_addr;
            r_w_data <= r_s_data;
            r_w_be_n <= r_s_be_n;
            r_we_cnt <= 4'd1;
          end
        end
        W_ACTIVE: begin
          if (w_wr_low) begin
            // Latched values stay put even if the pins wander
            if (r_we_cnt != 4'd15) r_we_cnt <= r_we_cnt + 4'd1;
          end else begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Array is not reset; an interrupted write never reaches it because reset
  // forces the FSM back to idle before any commit.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      if (!r_w_be_n[0]) r_mem[r_w_addr][7:0]  <= r_w_data[7:0];
      if (!r_w_be_n[1]) r_mem[r_w_addr][15:8] <= r_w_data[15:8];
    end
  end

  // Read path; data is re-registered every cycle in the valid window so it
  // tracks array updates while the address is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_cnt       <= 4'd0;
      sram_data_in_o <= INVALID_DATA;
      rd_valid_o     <= 1'b0;
    end else begin
      r_rd_cnt <= w_rd_cnt_nxt;
      if (w_rd_hit) begin
        sram_data_in_o <= r_mem[r_s_addr];
        rd_valid_o     <= 1'b1;
      end else begin
        sram_data_in_o <= INVALID_DATA;
        rd_valid_o     <= 1'b0;
      end
    end
  end

  // Counters and sticky flags; an event in the clear cycle wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_count_o   <= '0;
      read_count_o    <= '0;
      viol_we_width_o <= 1'b0;
      viol_addr_o     <= 1'b0;
      viol_conflict_o <= 1'b0;
    end else begin
      if (w_commit)     write_count_o <= clear_i ? 16'd1 : write_count_o + 16'd1;
      else if (clear_i) write_count_o <= '0;
      if (w_rd_done)    read_count_o  <= clear_i ? 16'd1 : read_count_o + 16'd1;
      else if (clear_i) read_count_o  <= '0;
      viol_we_width_o <= w_width_viol | (viol_we_width_o & !clear_i);
      viol_addr_o     <= w_addr_viol  | (viol_addr_o     & !clear_i);
      viol_conflict_o <= w_conflict   | (viol_conflict_o & !clear_i);
    end
  end

endmodule

// File: tb/tb_asram16_device_model.sv
module tb_asram16_device_model;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i;
  logic [31:0] sram_address_i;
  logic [15:0] sram_data_out_i;
  logic        sram_oe_n_i, sram_cs_n_i, sram_we_n_i;
  logic [1:0]  sram_be_n_i;
  logic [15:0] sram_data_in_o, write_count_o, read_count_o;
  logic        rd_valid_o, viol_we_width_o, viol_addr_o, viol_conflict_o;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_wc   = 0;
  int exp_rc   = 0;

  asram16_device_model dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .sram_address_i(sram_address_i), .sram_data_out_i(sram_data_out_i),
    .sram_oe_n_i(sram_oe_n_i), .sram_cs_n_i(sram_cs_n_i),
    .sram_be_n_i(sram_be_n_i), .sram_we_n_i(sram_we_n_i),
    .sram_data_in_o(sram_data_in_o), .rd_valid_o(rd_valid_o),
    .write_count_o(write_count_o), .read_count_o(read_count_o),
    .viol_we_width_o(viol_we_width_o), .viol_addr_o(viol_addr_o),
    .viol_conflict_o(viol_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, viol_we_width_o, viol_addr_o, viol_conflict_o}, {29'd0, exp});
  endtask

  task automatic idle();
    sram_cs_n_i = 1'b1; sram_we_n_i = 1'b1; sram_oe_n_i = 1'b1;
  endtask

  // Write with we_n low for n sampled cycles, then release; commit lands
  // two edges after the release is driven.
  task automatic write(input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] be, input int n);
    sram_address_i = a; sram_data_out_i = d; sram_be_n_i = be;
    sram_cs_n_i = 1'b0; sram_we_n_i = 1'b0;
    repeat (n) tick();
    idle();
    tick(); tick();
    exp_wc++;
  endtask

  // Address settles with cs_n high, then a held read: invalid for three
  // edges, valid on the fourth.
  task automatic read(input string tag, input logic [31:0] a, input logic [15:0] exp);
    sram_address_i = a; idle();
    tick();
    sram_cs_n_i = 1'b0; sram_oe_n_i = 1'b0;
    tick(); tick(); tick();
    chk({tag, "_pre_valid"}, {31'd0, rd_valid_o}, 32'd0);
    chk({tag, "_pre_data"}, {16'd0, sram_data_in_o}, 32'h0000DEAD);
    tick();
    exp_rc++;
    chk({tag, "_valid"}, {31'd0, rd_valid_o}, 32'd1);
    chk({tag, "_data"}, {16'd0, sram_data_in_o}, {16'd0, exp});
    chk({tag, "_rcount"}, {16'd0, read_count_o}, exp_rc);
    idle();
    tick();
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0;
    sram_address_i = '0; sram_data_out_i = '0; sram_be_n_i = 2'b11;
    idle();
    tick(); tick();
    chk("rst_data", {16'd0, sram_data_in_o}, 32'h0000DEAD);
    chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_wcount", {16'd0, write_count_o}, 32'd0);
    chk("rst_rcount", {16'd0, read_count_o}, 32'd0);
    chk_flags("rst_flags", 3'b000);
    rst_i = 1'b0;
    tick();

    // Full write then readback
    write(32'h10, 16'h1234, 2'b00, 3);
    chk("w1_wcount", {16'd0, write_count_o}, exp_wc);
    chk_flags("w1_flags", 3'b000);
    read("r1", 32'h10, 16'h1234);

    // Held read, then address move drops valid
    sram_address_i = 32'h10; sram_cs_n_i = 1'b0; sram_oe_n_i = 1'b0;
    repeat (4) tick();
    exp_rc++;
    chk("hold_valid", {31'd0, rd_valid_o}, 32'd1);
    tick();
    chk("hold_rcount", {16'd0, read_count_o}, exp_rc);
    sram_address_i = 32'h11;
    tick(); tick();
    chk("move_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("move_data", {16'd0, sram_data_in_o}, 32'h0000DEAD);
    idle(); tick();

    // Byte lanes: low byte only, then no lanes
    write(32'h10, 16'hABCD, 2'b10, 3);
    read("lane_lo", 32'h10, 16'h12CD);
    write(32'h10, 16'hFFFF, 2'b11, 3);
    chk("lane_none_wcount", {16'd0, write_count_o}, exp_wc);
    read("lane_none", 32'h10, 16'h12CD);
    // Upper address bits alias onto the same word
    read("alias", 32'h410, 16'h12CD);
    chk_flags("lanes_flags", 3'b000);

    // Short we_n pulse still commits
    write(32'h30, 16'h5555, 2'b00, 1);
    chk_flags("short_flags", 3'b100);
    chk("short_wcount", {16'd0, write_count_o}, exp_wc);
    read("short", 32'h30, 16'h5555);

    // Address moves mid-write; original latched address is written
    sram_address_i = 32'h40; sram_data_out_i = 16'h7777; sram_be_n_i = 2'b00;
    sram_cs_n_i = 1'b0; sram_we_n_i = 1'b0;
    tick(); tick();
    sram_address_i = 32'h41;
    tick(); tick();
    idle(); tick(); tick();
    exp_wc++;
    chk_flags("addr_flags", 3'b110);
    chk("addr_wcount", {16'd0, write_count_o}, exp_wc);
    read("addr_orig", 32'h40, 16'h7777);

    // Conflict: read path stays off, write still commits
    sram_address_i = 32'h50; sram_data_out_i = 16'h1111;
    sram_cs_n_i = 1'b0; sram_we_n_i = 1'b0; sram_oe_n_i = 1'b0;
    repeat (5) tick();
    chk("conf_valid", {31'd0, rd_valid_o}, 32'd0);
    idle(); tick(); tick();
    exp_wc++;
    chk_flags("conf_flags", 3'b111);
    chk("conf_wcount", {16'd0, write_count_o}, exp_wc);
    read("conf_data", 32'h50, 16'h1111);

    // Clear
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    exp_wc = 0; exp_rc = 0;
    chk_flags("clr_flags", 3'b000);
    chk("clr_wcount", {16'd0, write_count_o}, 32'd0);
    chk("clr_rcount", {16'd0, read_count_o}, 32'd0);

    // Event in the clear cycle wins
    sram_address_i = 32'h60; sram_data_out_i = 16'h6666;
    sram_cs_n_i = 1'b0; sram_we_n_i = 1'b0; sram_oe_n_i = 1'b0;
    tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk_flags("clr_prio_flags", 3'b001);
    idle(); tick(); tick();
    exp_wc++;
    chk("clr_prio_wcount", {16'd0, write_count_o}, exp_wc);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    exp_wc = 0;

    // Reset mid-write discards the pending write
    write(32'h70, 16'h2222, 2'b00, 3);
    sram_address_i = 32'h70; sram_data_out_i = 16'h9999; sram_be_n_i = 2'b00;
    sram_cs_n_i = 1'b0; sram_we_n_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b1; #1;
    exp_wc = 0; exp_rc = 0;
    chk("mid_rst_wcount", {16'd0, write_count_o}, 32'd0);
    chk("mid_rst_data", {16'd0, sram_data_in_o}, 32'h0000DEAD);
    chk("mid_rst_valid", {31'd0, rd_valid_o}, 32'd0);
    idle(); tick(); tick();
    rst_i = 1'b0; tick(); tick();
    chk("post_rst_wcount", {16'd0, write_count_o}, 32'd0);
    read("post_rst", 32'h70, 16'h2222);

    // Back-to-back halfword writes with cs_n held low
    sram_be_n_i = 2'b00; sram_cs_n_i = 1'b0;
    sram_address_i = 32'h20; sram_data_out_i = 16'hAAAA; sram_we_n_i = 1'b0;
    tick(); tick();
    sram_we_n_i = 1'b1; tick();
    sram_address_i = 32'h21; sram_data_out_i = 16'hBBBB; sram_we_n_i = 1'b0;
    tick(); tick();
    sram_we_n_i = 1'b1; tick();
    sram_cs_n_i = 1'b1; tick(); tick();
    exp_wc += 2;
    chk("b2b_wcount", {16'd0, write_count_o}, exp_wc);
    chk_flags("b2b_flags", 3'b000);
    read("b2b_lo", 32'h20, 16'hAAAA);
    read("b2b_hi", 32'h21, 16'hBBBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/asram16_device_model.md
Name: asram16_device_model

Overview:
- Synthesizable pin-level responder that emulates a 16-bit asynchronous SRAM, for on-FPGA loopback and simulation of the AXI4-to-async-SRAM controller.
- Connects directly to the controller's SRAM pins, samples them on the same clock, and stores data in an internal 2^ADDR_W x 16 array.
- Returns read data after a programmable access latency.
- Checks the controller's pin timing and reports violations through sticky flags and counters.

Parameters:
- ADDR_W, 10: word-address bits used; address bits [31:ADDR_W] are ignored, so addresses alias.
- READ_LATENCY, 4'd3: clocks from a stable read address to valid data; legal range 1..15.
- MIN_WE_CYCLES, 4'd2: minimum number of sampled cycles that we_n must stay low for a legal write.
- INVALID_DATA, 16'hDEAD: value driven on sram_data_in_o while read data is not valid.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear of counters and sticky flags
- sram_address_i  in  32  word address from the controller
- sram_data_out_i  in  16  write data from the controller
- sram_oe_n_i  in  1  output enable, active low
- sram_cs_n_i  in  1  chip select, active low
- sram_be_n_i  in  2  byte enables, active low; bit0 = [7:0]
- sram_we_n_i  in  1  write enable, active low
- sram_data_in_o  out  16  read data returned to the controller
- rd_valid_o  out  1  sram_data_in_o holds valid array data
- write_count_o  out  16  number of committed writes, wraps
- read_count_o  out  16  number of completed read accesses, wraps
- viol_we_width_o  out  1  sticky: a we_n low pulse was shorter than MIN_WE_CYCLES
- viol_addr_o  out  1  sticky: address or data changed while we_n was low
- viol_conflict_o  out  1  sticky: we_n and oe_n were low together while cs_n was low

Behaviour:
- Reset values:
  - sram_data_in_o = INVALID_DATA, rd_valid_o = 0.
  - Both counters = 0, all three flags = 0.
  - Sampled pins reset to the idle state: cs_n = we_n = oe_n = 1, be_n = 11, address = 0.
  - Array contents are not reset.
- Input stage: every pin is registered once (the "s" stage). All decisions below use sampled values.
- Write path, tracked by a state machine:
  - W_IDLE: on sampled cs_n=0 and we_n=0, go to W_ACTIVE. Latch address[ADDR_W-1:0], data and be_n. Set we_cnt=1.
  - W_ACTIVE, we_n still 0:
    - we_cnt increments, saturating at 15.
    - If address or data differs from the latched value, set viol_addr_o. The latched values are not updated.
  - W_ACTIVE, we_n rises to 1 (or cs_n rises):
    - Commit the latched data to the array, enabling only the lanes whose be_n bit is 0.
    - be_n = 11 still counts as a commit but writes nothing.
    - Increment write_count_o.
    - If we_cnt < MIN_WE_CYCLES, set viol_we_width_o; the write is still committed.
    - Return to W_IDLE.
  - Commit happens on the clock after the sampled rising edge. That write is visible to a read of the same address issued on the next cycle.
- Read path:
  - Read condition: sampled cs_n=0, oe_n=0 and we_n=1.
  - rd_cnt clears to 0 when the read condition is false or the sampled address differs from the previous sampled address. Otherwise it increments, saturating at READ_LATENCY.
  - When rd_cnt reaches READ_LATENCY:
    - sram_data_in_o is registered with array[address], and rd_valid_o = 1.
    - read_count_o increments once per stable address, on the transition into READ_LATENCY only.
  - Otherwise sram_data_in_o = INVALID_DATA and rd_valid_o = 0.
  - Net timing: valid data appears READ_LATENCY+1 edges after the pins first present a stable read, which includes the input sampling stage.
  - Read data follows array updates while the address stays stable.
- Conflict:
  - Sampled cs_n=0, we_n=0 and oe_n=0 sets viol_conflict_o.
  - In that state the read path is treated as inactive and the write path still operates.
- clear_i: zeroes both counters and all flags. If an event occurs in the same cycle as clear_i, the event takes priority and the counter or flag ends at 1.
- Reset in the middle of a write (W_ACTIVE): the pending write is discarded and the array is unchanged.
- Counters wrap from 16'hFFFF to 0.

Test Plan:
- Full write, READ_LATENCY=3: drive address 0x10, data 0x1234, be_n=00, we_n low for 3 cycles then high -> array[0x10]=0x1234, write_count_o=1, no flags set.
- Read back address 0x10 with oe_n=0 held: output is 16'hDEAD for 3 edges; on the 4th edge sram_data_in_o=0x1234, rd_valid_o=1, read_count_o=1. Change the address -> rd_valid_o=0 on the next cycle.
- Byte-lane write: write 0xABCD with be_n=10 over 0x1234 -> read returns 0x12CD. Write with be_n=11 -> data unchanged, write_count_o increments.
- Short we_n pulse (1 cycle) with MIN_WE_CYCLES=2 -> write commits and viol_we_width_o=1. Changing the address mid-pulse -> viol_addr_o=1 and the original latched address is written.
- we_n, oe_n and cs_n all low together -> viol_conflict_o=1 and rd_valid_o stays 0. Pulse clear_i -> all flags and counters return to 0.
- Assert rst_i during W_ACTIVE -> no commit, write_count_o=0, outputs at reset values. Back-to-back controller-style two-halfword write to addresses 0x20 and 0x21 -> both committed, write_count_o=2.
